// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch with one-entry output slot.
//
// Fetches instructions from code_memory at PC. Each fetched word is held in
// a registered output slot together with the PC it came from. The slot is
// emptied when the consumer accepts the word.
//
// A jump request redirects PC and discards any instruction the consumer has
// not accepted. It wins over every other event, including a halt requested
// in the same cycle.
//
// A halt request stops fetching. The held instruction is drained first, then
// the block parks in HALTED until a jump arrives.
//
// Ports:
//   in_clk          sole clock, rising edge
//   in_reset_n      asynchronous active-low reset
//   out_mem_addr    read address to code_memory (the PC register itself)
//   in_mem_data     combinational read data for out_mem_addr
//   out_instr       registered instruction word
//   out_instr_pc    address out_instr was fetched from
//   out_instr_valid out_instr / out_instr_pc valid
//   in_instr_ready  consumer accepts out_instr this cycle
//   in_jump         one-cycle redirect request
//   in_jump_addr    redirect target
//   in_halt         one-cycle stop request
//   out_halted      high only in HALTED
//
// state  | meaning
// RUN    | fetching whenever the output slot is free
// DRAIN  | halt requested; waiting for the held instruction to leave
// HALTED | fetch stopped; only a jump resumes
module fetch_controller #(
  parameter logic [8:0] RESET_PC = 9'h000
) (
  input  logic        in_clk,
  input  logic        in_reset_n,
  output logic [8:0]  out_mem_addr,
  input  logic [15:0] in_mem_data,
  output logic [15:0] out_instr,
  output logic [8:0]  out_instr_pc,
  output logic        out_instr_valid,
  input  logic        in_instr_ready,
  input  logic        in_jump,
  input  logic [8:0]  in_jump_addr,
  input  logic        in_halt,
  output logic        out_halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [8:0]  instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        slot_free;

  // ready is meaningless while nothing is presented
  assign slot_free = !valid_q || in_instr_ready;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 9'h000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    if (in_jump) begin
      // an unaccepted instruction is simply dropped
      state_d = RUN;
      pc_d    = in_jump_addr;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (in_halt) begin
            // no fetch this cycle; a word accepted now must not reappear
            state_d = DRAIN;
            valid_d = valid_q && !in_instr_ready;
          end else if (slot_free) begin
            instr_d    = in_mem_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 9'd1;   // wraps 1FF -> 000
          end
        end
        DRAIN: begin
          if (slot_free) begin
            state_d = HALTED;
            valid_d = 1'b0;
          end
        end
        HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign out_mem_addr    = pc_q;
  assign out_instr       = instr_q;
  assign out_instr_pc    = instr_pc_q;
  assign out_instr_valid = valid_q;
  assign out_halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam logic [8:0] RESET_PC = 9'h000;

  logic        in_clk;
  logic        in_reset_n;
  logic [8:0]  out_mem_addr;
  logic [15:0] in_mem_data;
  logic [15:0] out_instr;
  logic [8:0]  out_instr_pc;
  logic        out_instr_valid;
  logic        in_instr_ready;
  logic        in_jump;
  logic [8:0]  in_jump_addr;
  logic        in_halt;
  logic        out_halted;

  logic [15:0] mem [0:511];
  assign in_mem_data = mem[out_mem_addr];

  fetch_controller #(.RESET_PC(RESET_PC)) dut (
    .in_clk          (in_clk),
    .in_reset_n      (in_reset_n),
    .out_mem_addr    (out_mem_addr),
    .in_mem_data     (in_mem_data),
    .out_instr       (out_instr),
    .out_instr_pc    (out_instr_pc),
    .out_instr_valid (out_instr_valid),
    .in_instr_ready  (in_instr_ready),
    .in_jump         (in_jump),
    .in_jump_addr    (in_jump_addr),
    .in_halt         (in_halt),
    .out_halted      (out_halted)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the consumer sees a stream of (addr, word) pairs.
  // "fetching" = normal operation, "stopping" = halt requested with word
  // possibly still waiting, "parked" = halted.
  localparam int FETCHING = 0, STOPPING = 1, PARKED = 2;
  int          m_phase;
  logic [8:0]  m_pc;
  logic        m_has_word;
  logic [15:0] m_word;
  logic [8:0]  m_word_addr;
  logic        m_taken;

  always @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      m_phase     <= FETCHING;
      m_pc        <= RESET_PC;
      m_has_word  <= 1'b0;
      m_word      <= 16'h0000;
      m_word_addr <= 9'h000;
    end else begin
      m_taken = m_has_word && in_instr_ready;
      if (in_jump) begin
        m_phase    <= FETCHING;
        m_pc       <= in_jump_addr;
        m_has_word <= 1'b0;
      end else if (m_phase == FETCHING && in_halt) begin
        m_phase <= STOPPING;
        if (m_taken) m_has_word <= 1'b0;
      end else if (m_phase == FETCHING) begin
        if (!m_has_word || m_taken) begin
          m_word      <= mem[m_pc];
          m_word_addr <= m_pc;
          m_has_word  <= 1'b1;
          m_pc        <= 9'((int'(m_pc) + 1) % 512);
        end
      end else if (m_phase == STOPPING) begin
        if (!m_has_word || m_taken) begin
          m_has_word <= 1'b0;
          m_phase    <= PARKED;
        end
      end
    end
  end

  always @(negedge in_clk) begin
    chk("mdl_addr", 32'(out_mem_addr), 32'(m_pc));
    chk("mdl_valid", 32'(out_instr_valid), 32'(m_has_word));
    chk("mdl_halted", 32'(out_halted), 32'(m_phase == PARKED));
    if (m_has_word) begin
      chk("mdl_instr", 32'(out_instr), 32'(m_word));
      chk("mdl_instr_pc", 32'(out_instr_pc), 32'(m_word_addr));
    end
  end

  task automatic step(input logic r, input logic j, input logic [8:0] ja, input logic h);
    in_instr_ready = r;
    in_jump        = j;
    in_jump_addr   = ja;
    in_halt        = h;
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h3000 ^ 16'(i * 37);
    mem[0]     = 16'hF0F0;
    mem[1]     = 16'h0F0F;
    mem[9'h1FF] = 16'hAAAA;

    in_reset_n     = 1'b0;
    in_instr_ready = 1'b1;
    in_jump        = 1'b0;
    in_jump_addr   = 9'h000;
    in_halt        = 1'b0;

    #3;
    chk("rst_addr", 32'(out_mem_addr), 32'h000);
    chk("rst_valid", 32'(out_instr_valid), 32'h0);
    chk("rst_instr", 32'(out_instr), 32'h0000);
    chk("rst_instr_pc", 32'(out_instr_pc), 32'h000);
    chk("rst_halted", 32'(out_halted), 32'h0);

    step(1, 0, 9'h000, 0);
    step(1, 0, 9'h000, 0);
    in_reset_n = 1'b1;

    // startup stream
    step(1, 0, 9'h000, 0);
    chk("e1_instr", 32'(out_instr), 32'hF0F0);
    chk("e1_pc", 32'(out_instr_pc), 32'h000);
    chk("e1_valid", 32'(out_instr_valid), 32'h1);
    step(1, 0, 9'h000, 0);
    chk("e2_instr", 32'(out_instr), 32'h0F0F);
    chk("e2_pc", 32'(out_instr_pc), 32'h001);
    chk("e2_addr", 32'(out_mem_addr), 32'h002);

    // backpressure after first fetch
    step(1, 1, 9'h000, 0);
    chk("bp_jvalid", 32'(out_instr_valid), 32'h0);
    step(1, 0, 9'h000, 0);
    chk("bp_first", 32'(out_instr), 32'hF0F0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 9'h000, 0);
      chk("bp_hold_instr", 32'(out_instr), 32'hF0F0);
      chk("bp_hold_addr", 32'(out_mem_addr), 32'h001);
    end
    step(1, 0, 9'h000, 0);
    chk("bp_next", 32'(out_instr), 32'h0F0F);
    chk("bp_next_pc", 32'(out_instr_pc), 32'h001);

    // jump to top of memory and wrap
    step(1, 1, 9'h1FF, 0);
    chk("wr_valid", 32'(out_instr_valid), 32'h0);
    chk("wr_addr", 32'(out_mem_addr), 32'h1FF);
    step(1, 0, 9'h000, 0);
    chk("wr_instr", 32'(out_instr), 32'hAAAA);
    chk("wr_pc", 32'(out_instr_pc), 32'h1FF);
    chk("wr_addr0", 32'(out_mem_addr), 32'h000);
    step(1, 0, 9'h000, 0);
    chk("wr_instr2", 32'(out_instr), 32'hF0F0);
    chk("wr_pc2", 32'(out_instr_pc), 32'h000);

    // halt with a stalled word
    step(0, 0, 9'h000, 1);
    chk("hl_drain_halted", 32'(out_halted), 32'h0);
    chk("hl_drain_valid", 32'(out_instr_valid), 32'h1);
    chk("hl_drain_addr", 32'(out_mem_addr), 32'h001);
    step(1, 0, 9'h000, 0);
    chk("hl_halted", 32'(out_halted), 32'h1);
    chk("hl_valid", 32'(out_instr_valid), 32'h0);
    step(1, 0, 9'h000, 1);
    chk("hl_stay", 32'(out_halted), 32'h1);
    chk("hl_stay_addr", 32'(out_mem_addr), 32'h001);
    step(1, 1, 9'h000, 0);
    chk("hl_resume_halted", 32'(out_halted), 32'h0);
    chk("hl_resume_valid", 32'(out_instr_valid), 32'h0);
    step(1, 0, 9'h000, 0);
    chk("hl_resume_instr", 32'(out_instr), 32'hF0F0);

    // jump and halt together: jump wins
    step(1, 1, 9'h001, 1);
    chk("jh_halted", 32'(out_halted), 32'h0);
    chk("jh_addr", 32'(out_mem_addr), 32'h001);
    step(1, 0, 9'h000, 0);
    chk("jh_instr", 32'(out_instr), 32'h0F0F);
    chk("jh_valid", 32'(out_instr_valid), 32'h1);

    // mixed traffic, checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      logic r, j, h;
      r = ($urandom_range(0, 3) != 0);
      j = ($urandom_range(0, 15) == 0);
      h = ($urandom_range(0, 11) == 0);
      step(r, j, 9'($urandom_range(0, 511)), h);
    end

    // asynchronous reset mid-stream
    step(1, 1, 9'h000, 0);
    step(1, 0, 9'h000, 0);
    chk("ar_pre_valid", 32'(out_instr_valid), 32'h1);
    in_reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_instr_valid), 32'h0);
    chk("ar_addr", 32'(out_mem_addr), 32'(RESET_PC));
    chk("ar_halted", 32'(out_halted), 32'h0);
    step(1, 0, 9'h000, 0);
    in_reset_n = 1'b1;
    step(1, 0, 9'h000, 0);
    chk("ar_restart", 32'(out_instr), 32'hF0F0);
    chk("ar_restart_pc", 32'(out_instr_pc), 32'h000);
    step(1, 0, 9'h000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
